// File: rtl/pipe_pkg.sv
// Shared pipeline constants: control-group layout and instruction field positions.
// Imported by the ID/EX register, its hazard detector and later the forwarding unit.
package pipe_pkg;

    localparam int WB_W = 2;
    localparam int M_W  = 2;
    localparam int EX_W = 4;

    // WB = {RegWrite, MemtoReg}, M = {MemWrite, MemRead}, EX = {ALUSrc, ALUOp[1:0], RegDst}
    localparam int REGWRITE = 1;
    localparam int MEMTOREG = 0;
    localparam int MEMWRITE = 1;
    localparam int MEMREAD  = 0;
    localparam int ALUSRC   = 3;
    localparam int REGDST   = 0;

    localparam int RS_HI = 25;
    localparam int RS_LO = 21;
    localparam int RT_HI = 20;
    localparam int RT_LO = 16;
    localparam int RD_HI = 15;
    localparam int RD_LO = 11;

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// Decode-to-execute bundle: ID-side inputs, EX-side registered outputs,
// the load-use stall back to fetch and the bubble counter.
interface id_ex_pipe_reg_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int WB_W   = 2,
    parameter int M_W    = 2,
    parameter int EX_W   = 4,
    parameter int CNT_W  = 16
);

    logic              id_valid;
    logic [WB_W-1:0]   id_wb;
    logic [M_W-1:0]    id_m;
    logic [EX_W-1:0]   id_ex;
    logic [XLEN-1:0]   id_pc4;
    logic [XLEN-1:0]   id_rd1;
    logic [XLEN-1:0]   id_rd2;
    logic [XLEN-1:0]   id_imm;
    logic [XLEN-1:0]   id_instr;
    logic              ext_stall;
    logic              flush;

    logic              ex_valid;
    logic [WB_W-1:0]   ex_wb;
    logic [M_W-1:0]    ex_m;
    logic [EX_W-1:0]   ex_ex;
    logic [XLEN-1:0]   ex_pc4;
    logic [XLEN-1:0]   ex_rd1;
    logic [XLEN-1:0]   ex_rd2;
    logic [XLEN-1:0]   ex_imm;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic [REG_AW-1:0] ex_rd;
    logic              hazard_stall;
    logic [CNT_W-1:0]  bubble_cnt;

    modport master (
        output id_valid, id_wb, id_m, id_ex,
        output id_pc4, id_rd1, id_rd2, id_imm, id_instr,
        output ext_stall, flush,
        input  ex_valid, ex_wb, ex_m, ex_ex,
        input  ex_pc4, ex_rd1, ex_rd2, ex_imm,
        input  ex_rs, ex_rt, ex_rd,
        input  hazard_stall, bubble_cnt
    );

    modport slave (
        input  id_valid, id_wb, id_m, id_ex,
        input  id_pc4, id_rd1, id_rd2, id_imm, id_instr,
        input  ext_stall, flush,
        output ex_valid, ex_wb, ex_m, ex_ex,
        output ex_pc4, ex_rd1, ex_rd2, ex_imm,
        output ex_rs, ex_rt, ex_rd,
        output hazard_stall, bubble_cnt
    );

endinterface

// File: rtl/id_ex_pipe_reg_load_use_detect.sv
// Load-use hazard: a valid load in EX whose destination (rt, non-zero)
// is a source of the valid instruction in ID.
module load_use_detect #(
    parameter int REG_AW    = 5,
    parameter int HAZARD_EN = 1
) (
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              ex_valid,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] ex_rt,
    output logic              hazard
);

    logic rt_nz;
    logic match;

    assign rt_nz  = (ex_rt != '0);
    assign match  = (ex_rt == id_rs) || (ex_rt == id_rt);
    assign hazard = (HAZARD_EN != 0) && id_valid && ex_valid
                    && ex_memread && rt_nz && match;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with flush, external stall, load-use bubble
// insertion and a saturating bubble counter.
module id_ex_pipe_reg
    import pipe_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int REG_AW      = 5,
    parameter int WB_W        = pipe_pkg::WB_W,
    parameter int M_W         = pipe_pkg::M_W,
    parameter int EX_W        = pipe_pkg::EX_W,
    parameter int MEMREAD_BIT = pipe_pkg::MEMREAD,
    parameter int HAZARD_EN   = 1,
    parameter int CNT_W       = 16
) (
    input logic            clk,
    input logic            rst,
    id_ex_pipe_reg_if.slave bus
);

    logic              valid_q;
    logic [WB_W-1:0]   wb_q;
    logic [M_W-1:0]    m_q;
    logic [EX_W-1:0]   ex_q;
    logic [XLEN-1:0]   pc4_q;
    logic [XLEN-1:0]   rd1_q;
    logic [XLEN-1:0]   rd2_q;
    logic [XLEN-1:0]   imm_q;
    logic [REG_AW-1:0] rs_q;
    logic [REG_AW-1:0] rt_q;
    logic [REG_AW-1:0] rd_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_rd;
    logic              hazard;

    assign id_rs = bus.id_instr[RS_HI:RS_LO];
    assign id_rt = bus.id_instr[RT_HI:RT_LO];
    assign id_rd = bus.id_instr[RD_HI:RD_LO];

    load_use_detect #(
        .REG_AW    (REG_AW),
        .HAZARD_EN (HAZARD_EN)
    ) u_lud (
        .id_valid   (bus.id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .ex_valid   (valid_q),
        .ex_memread (m_q[MEMREAD_BIT]),
        .ex_rt      (rt_q),
        .hazard     (hazard)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            wb_q    <= '0;
            m_q     <= '0;
            ex_q    <= '0;
            pc4_q   <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else if (bus.flush) begin
            valid_q <= 1'b0;
            wb_q    <= '0;
            m_q     <= '0;
            ex_q    <= '0;
            pc4_q   <= bus.id_pc4;
            rd1_q   <= bus.id_rd1;
            rd2_q   <= bus.id_rd2;
            imm_q   <= bus.id_imm;
            rs_q    <= id_rs;
            rt_q    <= id_rt;
            rd_q    <= id_rd;
        end else if (bus.ext_stall) begin
            valid_q <= valid_q;
        end else if (hazard) begin
            // bubble: kill control, keep datapath so the load stays visible
            valid_q <= 1'b0;
            wb_q    <= '0;
            m_q     <= '0;
            ex_q    <= '0;
            if (cnt_q != '1) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end else begin
            valid_q <= bus.id_valid;
            wb_q    <= bus.id_valid ? bus.id_wb : '0;
            m_q     <= bus.id_valid ? bus.id_m  : '0;
            ex_q    <= bus.id_valid ? bus.id_ex : '0;
            pc4_q   <= bus.id_pc4;
            rd1_q   <= bus.id_rd1;
            rd2_q   <= bus.id_rd2;
            imm_q   <= bus.id_imm;
            rs_q    <= id_rs;
            rt_q    <= id_rt;
            rd_q    <= id_rd;
        end
    end

    assign bus.ex_valid     = valid_q;
    assign bus.ex_wb        = wb_q;
    assign bus.ex_m         = m_q;
    assign bus.ex_ex        = ex_q;
    assign bus.ex_pc4       = pc4_q;
    assign bus.ex_rd1       = rd1_q;
    assign bus.ex_rd2       = rd2_q;
    assign bus.ex_imm       = imm_q;
    assign bus.ex_rs        = rs_q;
    assign bus.ex_rt        = rt_q;
    assign bus.ex_rd        = rd_q;
    assign bus.hazard_stall = hazard;
    assign bus.bubble_cnt   = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg: a reference model pushes expected EX
// state into a scoreboard queue at drive time; it is popped after each edge.
module tb_id_ex_pipe_reg;

    typedef struct packed {
        logic        valid;
        logic [1:0]  wb;
        logic [1:0]  m;
        logic [3:0]  ex;
        logic [31:0] pc4;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] cnt;
    } snap_t;

    localparam logic [31:0] LW8  = 32'h8D28_0000;
    localparam logic [31:0] USE8 = 32'h0101_4820;
    localparam logic [31:0] LW0  = 32'h8C00_0000;
    localparam logic [31:0] USE0 = 32'h0000_1020;
    localparam logic [31:0] ADD  = 32'h012A_4020;

    logic clk;
    logic rst;

    id_ex_pipe_reg_if #(.CNT_W(16)) b1 ();
    id_ex_pipe_reg_if #(.CNT_W(2))  b2 ();

    id_ex_pipe_reg #(.CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (b1.slave)
    );

    id_ex_pipe_reg #(.CNT_W(2)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (b2.slave)
    );

    assign b2.id_valid  = b1.id_valid;
    assign b2.id_wb     = b1.id_wb;
    assign b2.id_m      = b1.id_m;
    assign b2.id_ex     = b1.id_ex;
    assign b2.id_pc4    = b1.id_pc4;
    assign b2.id_rd1    = b1.id_rd1;
    assign b2.id_rd2    = b1.id_rd2;
    assign b2.id_imm    = b1.id_imm;
    assign b2.id_instr  = b1.id_instr;
    assign b2.ext_stall = b1.ext_stall;
    assign b2.flush     = b1.flush;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_chk  = 0;
    int    n_fail = 0;
    snap_t mdl;
    logic [1:0] mcnt2;
    snap_t sb[$];

    function automatic snap_t obs();
        snap_t s;
        s.valid = b1.ex_valid;
        s.wb    = b1.ex_wb;
        s.m     = b1.ex_m;
        s.ex    = b1.ex_ex;
        s.pc4   = b1.ex_pc4;
        s.rd1   = b1.ex_rd1;
        s.rd2   = b1.ex_rd2;
        s.imm   = b1.ex_imm;
        s.rs    = b1.ex_rs;
        s.rt    = b1.ex_rt;
        s.rd    = b1.ex_rd;
        s.cnt   = b1.bubble_cnt;
        return s;
    endfunction

    task automatic chk(input string tag, input logic [255:0] o, input logic [255:0] e);
        n_chk++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic step(input logic v, input logic [1:0] wb, input logic [1:0] m,
                        input logic [3:0] ex, input logic [31:0] pc4,
                        input logic [31:0] rd1, input logic [31:0] rd2,
                        input logic [31:0] imm, input logic [31:0] instr,
                        input logic st, input logic fl);
        logic  haz;
        snap_t e;
        b1.id_valid  = v;
        b1.id_wb     = wb;
        b1.id_m      = m;
        b1.id_ex     = ex;
        b1.id_pc4    = pc4;
        b1.id_rd1    = rd1;
        b1.id_rd2    = rd2;
        b1.id_imm    = imm;
        b1.id_instr  = instr;
        b1.ext_stall = st;
        b1.flush     = fl;
        #1;
        haz = v && mdl.valid && mdl.m[0] && (mdl.rt != 5'd0)
              && ((mdl.rt == instr[25:21]) || (mdl.rt == instr[20:16]));
        chk("hazard_stall", b1.hazard_stall, haz);
        if (fl) begin
            mdl.valid = 1'b0;
            mdl.wb = '0; mdl.m = '0; mdl.ex = '0;
            mdl.pc4 = pc4; mdl.rd1 = rd1; mdl.rd2 = rd2; mdl.imm = imm;
            mdl.rs = instr[25:21]; mdl.rt = instr[20:16]; mdl.rd = instr[15:11];
        end else if (st) begin
            mdl = mdl;
        end else if (haz) begin
            mdl.valid = 1'b0;
            mdl.wb = '0; mdl.m = '0; mdl.ex = '0;
            if (mdl.cnt != 16'hFFFF) mdl.cnt = mdl.cnt + 16'd1;
            if (mcnt2 != 2'b11) mcnt2 = mcnt2 + 2'd1;
        end else begin
            mdl.valid = v;
            mdl.wb = v ? wb : 2'b00;
            mdl.m  = v ? m  : 2'b00;
            mdl.ex = v ? ex : 4'b0000;
            mdl.pc4 = pc4; mdl.rd1 = rd1; mdl.rd2 = rd2; mdl.imm = imm;
            mdl.rs = instr[25:21]; mdl.rt = instr[20:16]; mdl.rd = instr[15:11];
        end
        sb.push_back(mdl);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("ex_state", obs(), e);
        chk("sat_cnt", b2.bubble_cnt, mcnt2);
    endtask

    initial begin
        rst = 1'b1;
        mdl = '0;
        mcnt2 = 2'b00;
        b1.id_valid = 0; b1.id_wb = 0; b1.id_m = 0; b1.id_ex = 0;
        b1.id_pc4 = 0; b1.id_rd1 = 0; b1.id_rd2 = 0; b1.id_imm = 0;
        b1.id_instr = 0; b1.ext_stall = 0; b1.flush = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", obs(), snap_t'('0));
        chk("reset_hazard", b1.hazard_stall, 1'b0);
        rst = 1'b0;

        // pass-through of add $8,$9,$10
        step(1, 2'b10, 2'b00, 4'b0101, 32'h0040_0004, 32'h11, 32'h22, 32'h33, ADD, 0, 0);
        chk("pass_pc4", b1.ex_pc4, 32'h0040_0004);
        chk("pass_rs", b1.ex_rs, 5'd9);
        chk("pass_rt", b1.ex_rt, 5'd10);
        chk("pass_rd", b1.ex_rd, 5'd8);
        chk("pass_valid", b1.ex_valid, 1'b1);

        // invalid entry loads zero control
        step(0, 2'b11, 2'b11, 4'hF, 32'h8, 32'h1, 32'h2, 32'h3, ADD, 0, 0);
        chk("invalid_ctrl", {b1.ex_wb, b1.ex_m, b1.ex_ex}, 8'h00);

        // load-use: lw $8 then add $9,$8,$1
        step(1, 2'b11, 2'b01, 4'b1000, 32'h0040_0008, 32'h9, 32'h0, 32'h0, LW8, 0, 0);
        step(1, 2'b10, 2'b00, 4'b0101, 32'h0040_000C, 32'h5, 32'h6, 32'h0, USE8, 0, 0);
        chk("lu_bubble_valid", b1.ex_valid, 1'b0);
        chk("lu_bubble_cnt", b1.bubble_cnt, 16'd1);
        step(1, 2'b10, 2'b00, 4'b0101, 32'h0040_000C, 32'h5, 32'h6, 32'h0, USE8, 0, 0);
        chk("lu_consumer_in", {b1.ex_valid, b1.ex_pc4}, {1'b1, 32'h0040_000C});

        // load to $0 never stalls
        step(1, 2'b11, 2'b01, 4'b1000, 32'h10, 32'h0, 32'h0, 32'h0, LW0, 0, 0);
        step(1, 2'b10, 2'b00, 4'b0101, 32'h14, 32'h0, 32'h0, 32'h0, USE0, 0, 0);
        chk("ld0_no_bubble", {b1.ex_valid, b1.bubble_cnt}, {1'b1, 16'd1});

        // hazard under ext_stall holds without a bubble, then bubbles on release
        step(1, 2'b11, 2'b01, 4'b1000, 32'h20, 32'h9, 32'h0, 32'h0, LW8, 0, 0);
        step(1, 2'b10, 2'b00, 4'b0101, 32'h24, 32'h5, 32'h6, 32'h0, USE8, 1, 0);
        chk("stall_haz_cnt", b1.bubble_cnt, 16'd1);
        step(1, 2'b10, 2'b00, 4'b0101, 32'h24, 32'h5, 32'h6, 32'h0, USE8, 0, 0);
        chk("stall_rel_cnt", b1.bubble_cnt, 16'd2);

        // ext_stall freezes for 3 cycles, then flush wins
        step(1, 2'b10, 2'b00, 4'b0110, 32'h100, 32'hA, 32'hB, 32'hC, ADD, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 2'b11, 2'b10, 4'b1111, 32'h200 + i, 32'h1, 32'h2, 32'h3, LW8, 1, 0);
            chk("stall_hold", {b1.ex_valid, b1.ex_pc4, b1.ex_ex}, {1'b1, 32'h100, 4'b0110});
        end
        step(1, 2'b11, 2'b10, 4'b1111, 32'h300, 32'h1, 32'h2, 32'h3, LW8, 1, 1);
        chk("stall_flush", {b1.ex_valid, b1.ex_wb, b1.ex_m, b1.ex_ex}, 9'h000);

        // flush beats a pending hazard and does not count
        step(1, 2'b11, 2'b01, 4'b1000, 32'h400, 32'h9, 32'h0, 32'h0, LW8, 0, 0);
        step(1, 2'b10, 2'b00, 4'b0101, 32'h404, 32'h5, 32'h6, 32'h0, USE8, 0, 1);
        chk("flush_haz", {b1.ex_valid, b1.bubble_cnt}, {1'b0, 16'd2});

        // five back-to-back load-use pairs saturate the 2-bit counter
        for (int i = 0; i < 5; i++) begin
            step(1, 2'b11, 2'b01, 4'b1000, 32'h500, 32'h9, 32'h0, 32'h0, LW8, 0, 0);
            step(1, 2'b10, 2'b00, 4'b0101, 32'h504, 32'h5, 32'h6, 32'h0, USE8, 0, 0);
        end
        chk("sat_cnt_3", b2.bubble_cnt, 2'd3);
        chk("wide_cnt_7", b1.bubble_cnt, 16'd7);

        // asynchronous reset mid-cycle, then a normal load
        step(1, 2'b10, 2'b01, 4'b0101, 32'h600, 32'h7, 32'h8, 32'h9, ADD, 0, 0);
        rst = 1'b1;
        #1;
        chk("async_rst", obs(), snap_t'('0));
        chk("async_rst_sat", b2.bubble_cnt, 2'd0);
        #1;
        rst = 1'b0;
        mdl = '0;
        mcnt2 = 2'b00;
        step(1, 2'b10, 2'b00, 4'b0101, 32'h0040_0004, 32'h11, 32'h22, 32'h33, ADD, 0, 0);
        chk("post_rst_load", {b1.ex_valid, b1.ex_pc4}, {1'b1, 32'h0040_0004});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
Parametrised ID/EX pipeline register with valid bit, stall, flush and built-in load-use hazard detection. Sits between the decode and execute stages. Captures control groups (WB, M, EX), PC+4, both register read values, the sign-extended immediate, and the decoded rs/rt/rd fields. Inserts bubbles on flush and load-use hazards, holds on external stall, and keeps a saturating bubble counter for performance debug.

Parameters:
XLEN, 32, datapath width (PC+4, read data, immediate, instruction)
REG_AW, 5, register-address width (rs/rt/rd)
WB_W, 2, WB control group width {RegWrite, MemtoReg}
M_W, 2, M control group width {MemWrite, MemRead}
EX_W, 4, EX control group width {ALUSrc, ALUOp[1:0], RegDst}
MEMREAD_BIT, 0, bit index of MemRead inside the M group
HAZARD_EN, 1, 1 enables load-use detection; 0 ties hazard_stall to 0
CNT_W, 16, bubble counter width

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
id_valid  in  1  decode stage holds a real instruction
id_wb  in  WB_W  WB control from decode
id_m  in  M_W  M control from decode
id_ex  in  EX_W  EX control from decode
id_pc4  in  XLEN  PC+4
id_rd1  in  XLEN  register read data 1
id_rd2  in  XLEN  register read data 2
id_imm  in  XLEN  sign-extended immediate
id_instr  in  XLEN  raw instruction
ext_stall  in  1  a downstream stage is busy; hold contents
flush  in  1  branch/jump redirect; kill the instruction entering EX
ex_valid  out  1  EX stage instruction is valid
ex_wb  out  WB_W  registered WB control
ex_m  out  M_W  registered M control
ex_ex  out  EX_W  registered EX control
ex_pc4, ex_rd1, ex_rd2, ex_imm  out  XLEN each  registered datapath values
ex_rs, ex_rt, ex_rd  out  REG_AW each  instr[25:21], instr[20:16], instr[15:11]
hazard_stall  out  1  combinational; freezes the PC and IF/ID
bubble_cnt  out  CNT_W  count of bubbles inserted

Behaviour:
- Reset: when rst is asserted, all registered outputs clear to 0 immediately, independent of clk. This includes ex_valid and bubble_cnt. hazard_stall is therefore 0.
- Load-use hazard (combinational): hazard_stall = HAZARD_EN & id_valid & ex_valid & ex_m[MEMREAD_BIT] & (ex_rt != 0) & ((ex_rt == id_instr[25:21]) | (ex_rt == id_instr[20:16])).
- Per-edge update, evaluated in priority order:
  1. flush: ex_valid, ex_wb, ex_m and ex_ex all go to 0. Datapath and field registers load normally (don't-care contents). Flush wins over ext_stall and hazard.
  2. ext_stall: every register holds its value. hazard_stall is still driven, but no bubble is inserted.
  3. hazard_stall: insert a bubble. ex_valid and all control go to 0; datapath holds. bubble_cnt increments.
  4. Otherwise: load all inputs; ex_valid <= id_valid.
- Latency: exactly 1 cycle from ID inputs to EX outputs when none of the above conditions is active.
- A stalled-then-released load produces exactly one bubble. Next cycle ex_valid=0, so the hazard clears and the consumer enters EX.
- Control of invalid entries: when id_valid=0 on a normal load, ex_wb, ex_m and ex_ex load as 0, so a bubble can never write a register or memory.
- bubble_cnt saturates at all-ones; no wrap-around. It does not increment on flush.
- Field widths are fixed. rt is bits [20:16] and rd is bits [15:11]; the two fields do not overlap. Outputs are REG_AW wide with no zero-padding to XLEN.
- Reset deasserting mid-operation: the first edge after deassertion performs a normal load.

Decomposition:
- Shared package pipe_pkg holds:
  - control-group widths WB_W, M_W and EX_W, plus bit-index constants (REGWRITE, MEMTOREG, MEMWRITE, MEMREAD, ALUSRC, REGDST);
  - the instruction field positions RS_HI/LO, RT_HI/LO and RD_HI/LO.
- One combinational sub-module, load_use_detect, computes hazard_stall. It is reused later by the forwarding unit.

Test Plan:
- Reset: assert rst mid-cycle with non-zero contents -> all outputs 0 before the next edge; bubble_cnt=0.
- Pass-through: id_valid=1, id_pc4=0x00400004, id_instr=0x012A4020 (add $8,$9,$10) -> next cycle ex_pc4=0x00400004, ex_rs=9, ex_rt=10, ex_rd=8, ex_valid=1.
- Load-use: EX holds lw $8 (ex_m MemRead=1, ex_rt=8); ID holds add $9,$8,$1 -> hazard_stall=1; next cycle ex_valid=0, controls 0, bubble_cnt=1; following cycle the add enters EX.
- Load to $0: ex_rt=0 with MemRead and a matching ID rs=0 -> hazard_stall=0, no bubble.
- Stall vs flush: ext_stall=1 for 3 cycles -> outputs frozen. Then assert ext_stall and flush together -> ex_valid=0 and controls 0 after one edge.
- Counter saturation: CNT_W=2, force 5 consecutive hazards -> bubble_cnt stays at 3.
